// File: rtl/coin_conditioner.sv
// coin_conditioner: synchronise, debounce and arbitrate the coin5/coin10 sensors into single-cycle accept pulses
//   sys_clk     : system clock, all state on rising edge
//   sys_rst_n   : asynchronous active-low reset
//   coin5       : raw 5-unit coin sensor (async, active-high, bouncy)
//   coin10      : raw 10-unit coin sensor (async, active-high, bouncy)
//   have_coin5  : one-cycle pulse per accepted 5-unit coin
//   have_coin10 : one-cycle pulse per accepted 10-unit coin
//   coin_busy   : either channel outside IDLE or a pulse still pending
module coin_conditioner #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic coin5,
  input  logic coin10,
  output logic have_coin5,
  output logic have_coin10,
  output logic coin_busy
);
  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [1:0] IDLE = 2'd0, PRESS_WAIT = 2'd1, HELD = 2'd2, RELEASE_WAIT = 2'd3;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);
  logic [1:0] raw, meta, sync, qual, active, pend;
  assign raw = {coin10, coin5};
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  // bit 0 is the 5-unit channel, bit 1 the 10-unit channel
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [1:0] st;
    logic [CNT_W-1:0] cnt;
    assign qual[c] = st == PRESS_WAIT && sync[c] && cnt == LAST;
    assign active[c] = st != IDLE;
    always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
        st <= IDLE;
        cnt <= '0;
      end else
        case (st)
          IDLE:
            if (sync[c]) begin
              st <= PRESS_WAIT;
              cnt <= CNT_W'(1);
            end
          PRESS_WAIT:
            if (!sync[c]) begin
              st <= IDLE;
              cnt <= '0;
            end else if (cnt == LAST) begin
              st <= HELD;
              cnt <= '0;
            end else
              cnt <= cnt + CNT_W'(1);
          HELD:
            if (!sync[c]) begin
              st <= RELEASE_WAIT;
              cnt <= CNT_W'(1);
            end
          default:
            if (sync[c]) begin
              st <= HELD;
              cnt <= '0;
            end else if (cnt == LAST) begin
              st <= IDLE;
              cnt <= '0;
            end else
              cnt <= cnt + CNT_W'(1);
        endcase
  end
  // 10-unit pending wins; a 5-unit pending waits one cycle behind it
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      pend <= '0;
      have_coin5 <= 1'b0;
      have_coin10 <= 1'b0;
    end else begin
      have_coin10 <= pend[1];
      have_coin5 <= pend[0] & ~pend[1];
      pend[1] <= qual[1];
      pend[0] <= qual[0] | (pend[0] & pend[1]);
    end
  assign coin_busy = |active | |pend;
endmodule

// File: tb/tb_coin_conditioner.sv
// tb_coin_conditioner: directed scenarios plus random coin traffic checked against a run-length debounce model
module tb_coin_conditioner;
  localparam int DB = 8;
  logic sys_clk, sys_rst_n, coin5, coin10;
  logic have_coin5, have_coin10, coin_busy;
  int checks = 0, errors = 0, cyc = 0;
  int n5 = 0, n10 = 0, t5 = 0, t10 = 0;
  int b5, b10, t0, q5b, q10b;

  coin_conditioner #(.DB_CYCLES(DB)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .coin5(coin5), .coin10(coin10),
    .have_coin5(have_coin5), .have_coin10(have_coin10), .coin_busy(coin_busy)
  );

  initial sys_clk = 0;
  always #5 sys_clk = ~sys_clk;

  // Reference: a debounced level flips once the synchronised input has
  // disagreed with it for DB consecutive clock edges.
  logic m_r5a, m_r5b, m_r10a, m_r10b, m_d5, m_d10, m_p5, m_p10, m_h5, m_h10, q5, q10, m_busy;
  int m_run5, m_run10, mq5 = 0, mq10 = 0;

  function automatic void deb(input logic s, inout logic d, inout int run, output logic q);
    q = 0;
    if (s == d) run = 0;
    else if (run + 1 == DB) begin d = s; run = 0; q = s; end
    else run++;
  endfunction

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      {m_r5a, m_r5b, m_r10a, m_r10b, m_d5, m_d10, m_p5, m_p10, m_h5, m_h10} = '0;
      m_run5 = 0;
      m_run10 = 0;
    end else begin
      m_h10 = m_p10;
      m_h5 = m_p5 & !m_p10;
      m_p5 = m_p5 & m_p10;
      m_p10 = 0;
      deb(m_r5b, m_d5, m_run5, q5);
      deb(m_r10b, m_d10, m_run10, q10);
      m_p5 = m_p5 | q5;
      m_p10 = m_p10 | q10;
      mq5 += int'(q5);
      mq10 += int'(q10);
      m_r5b = m_r5a; m_r5a = coin5;
      m_r10b = m_r10a; m_r10a = coin10;
    end
  end
  assign m_busy = m_d5 | m_d10 | (m_run5 > 0) | (m_run10 > 0) | m_p5 | m_p10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
    cyc++;
    chk("have_coin5", 32'(have_coin5), 32'(m_h5));
    chk("have_coin10", 32'(have_coin10), 32'(m_h10));
    chk("coin_busy", 32'(coin_busy), 32'(m_busy));
    chk("mutex", 32'(have_coin5 & have_coin10), 0);
    if (have_coin5 === 1'b1) begin n5++; t5 = cyc; end
    if (have_coin10 === 1'b1) begin n10++; t10 = cyc; end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    sys_rst_n = 0; coin5 = 0; coin10 = 0;
    run(2);
    chk("reset_busy", 32'(coin_busy), 0);
    sys_rst_n = 1;
    run(3);
    // clean press
    b5 = n5; b10 = n10; t0 = cyc;
    coin5 = 1; run(30); coin5 = 0; run(30);
    chk("clean_cnt5", n5 - b5, 1);
    chk("clean_cnt10", n10 - b10, 0);
    chk("clean_lat", t5 - t0, 11);
    // press bounce
    b10 = n10;
    repeat (5) begin coin10 = 1; run(3); coin10 = 0; run(2); end
    t0 = cyc;
    coin10 = 1; run(20); coin10 = 0; run(30);
    chk("bounce_cnt10", n10 - b10, 1);
    chk("bounce_lat", t10 - t0, 11);
    // glitch rejection
    b5 = n5;
    coin5 = 1; run(6); coin5 = 0; run(10);
    chk("glitch_busy", 32'(coin_busy), 0);
    chk("glitch_cnt5", n5 - b5, 0);
    // simultaneous
    b5 = n5; b10 = n10; t0 = cyc;
    coin5 = 1; coin10 = 1; run(20); coin5 = 0; coin10 = 0; run(30);
    chk("simul_cnt5", n5 - b5, 1);
    chk("simul_cnt10", n10 - b10, 1);
    chk("simul_lat10", t10 - t0, 11);
    chk("simul_lat5", t5 - t0, 12);
    // release bounce and hold
    b10 = n10;
    coin10 = 1; run(20); coin10 = 0; run(3); coin10 = 1; run(10);
    t0 = cyc;
    coin10 = 0; run(9);
    chk("release_busy_hold", 32'(coin_busy), 1);
    run(1);
    chk("release_busy_idle", 32'(coin_busy), 0);
    run(20);
    chk("release_cnt10", n10 - b10, 1);
    // reset mid-press
    b5 = n5;
    coin5 = 1; run(7);
    sys_rst_n = 0;
    run(3);
    chk("rst_have5", 32'(have_coin5), 0);
    chk("rst_busy", 32'(coin_busy), 0);
    sys_rst_n = 1; t0 = cyc;
    run(20); coin5 = 0; run(30);
    chk("rst_cnt5", n5 - b5, 1);
    chk("rst_lat", t5 - t0, 11);
    // random traffic
    b5 = n5; b10 = n10; q5b = mq5; q10b = mq10;
    repeat (300) begin
      coin5 = 1'($urandom_range(0, 1));
      coin10 = 1'($urandom_range(0, 1));
      run(int'($urandom_range(1, 12)));
    end
    coin5 = 0; coin10 = 0; run(40);
    chk("rand_cnt5", n5 - b5, mq5 - q5b);
    chk("rand_cnt10", n10 - b10, mq10 - q10b);
    chk("rand_idle", 32'(coin_busy), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
